// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit divider.
// Contents: FSM state encoding, operand width and iteration-counter width.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : div_pkg

// File: rtl/cond_negate_32bit.sv
// Conditional two's-complement negation.
// Ports:
//   in  [31:0]  value to pass through or negate
//   neg         1 = output the two's complement of in, 0 = pass in unchanged
//   out [31:0]  (in XOR {32{neg}}) + neg
// The magnitude of 0x80000000 comes out as 0x80000000, which callers read
// as an unsigned value, so there is no overflow case.
module cond_negate_32bit (
    input  logic [31:0] in,
    input  logic        neg,
    output logic [31:0] out
);

    assign out = (in ^ {32{neg}}) + {31'd0, neg};

endmodule : cond_negate_32bit

// File: rtl/div_32bit_seq.sv
// Sequential 32-bit restoring divider, signed or unsigned per operation.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request a divide (accepted only in IDLE)
//   is_signed              1 = two's-complement divide, 0 = unsigned
//   dividend, divisor      operands, sampled with start
//   busy                   high from the accept edge to the done edge
//   done                   one-cycle pulse, results valid while high
//   quotient, remainder    results, held until the next completion
//   div_by_zero            last completed operation had divisor = 0
// Configuration macro:
//   DIV_ZERO_EARLY_EN      when defined, divisor = 0 skips RUN/FIX and
//                          completes one edge after start.
// Operation: magnitudes are divided with one shift-subtract step per cycle
// for 32 cycles, then the FIX state restores the signs (the remainder takes
// the dividend's sign).
module div_32bit_seq
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] quo_r, rem_r, dvs_abs_r, dvd_raw_r;
    logic             sgn_r, a_neg_r, b_neg_r, dvs_zero_r;
    logic             busy_r, done_r, dz_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;

    logic [WIDTH-1:0] dvd_abs_s, dvs_abs_s, quo_fix_s, rem_fix_s;
    logic [WIDTH:0]   sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s, early_dz_s, dvs_zero_s;

    // Operand magnitudes: invert+increment only for negative signed operands.
    cond_negate_32bit u_abs_dvd (
        .in  (dividend),
        .neg (is_signed & dividend[WIDTH-1]),
        .out (dvd_abs_s)
    );

    cond_negate_32bit u_abs_dvs (
        .in  (divisor),
        .neg (is_signed & divisor[WIDTH-1]),
        .out (dvs_abs_s)
    );

    // Result sign restoration applied in FIX.
    cond_negate_32bit u_fix_quo (
        .in  (quo_r),
        .neg (sgn_r & (a_neg_r ^ b_neg_r)),
        .out (quo_fix_s)
    );

    cond_negate_32bit u_fix_rem (
        .in  (rem_r),
        .neg (sgn_r & a_neg_r),
        .out (rem_fix_s)
    );

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The remainder is
    // always below the divisor, so the difference fits in WIDTH bits.
    assign sh_s   = {rem_r, quo_r[WIDTH-1]};
    assign ge_s   = (sh_s >= {1'b0, dvs_abs_r});
    assign diff_s = sh_s[WIDTH-1:0] - dvs_abs_r;

    assign dvs_zero_s = (divisor == {WIDTH{1'b0}});
`ifdef DIV_ZERO_EARLY_EN
    assign early_dz_s = dvs_zero_s;
`else
    assign early_dz_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. DONE entered directly from IDLE (early
    // divide-by-zero) lingers one edge so done rises one edge after start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (early_dz_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (done_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath, status flags and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvs_abs_r   <= {WIDTH{1'b0}};
            dvd_raw_r   <= {WIDTH{1'b0}};
            sgn_r       <= 1'b0;
            a_neg_r     <= 1'b0;
            b_neg_r     <= 1'b0;
            dvs_zero_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r      <= {CNT_W{1'b0}};
                        quo_r      <= dvd_abs_s;
                        rem_r      <= {WIDTH{1'b0}};
                        dvs_abs_r  <= dvs_abs_s;
                        dvd_raw_r  <= dividend;
                        sgn_r      <= is_signed;
                        a_neg_r    <= dividend[WIDTH-1];
                        b_neg_r    <= divisor[WIDTH-1];
                        dvs_zero_r <= dvs_zero_s;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (ge_s) begin
                        rem_r <= diff_s;
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= sh_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                end
                ST_FIX: begin
                    // Divide-by-zero results are forced rather than taken
                    // from the iteration.
                    if (dvs_zero_r) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dvd_raw_r;
                        dz_r        <= 1'b1;
                    end else begin
                        quotient_r  <= quo_fix_s;
                        remainder_r <= rem_fix_s;
                        dz_r        <= 1'b0;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                ST_DONE: begin
                    // done_r low here means DONE was entered straight from
                    // IDLE on a zero divisor: complete now.
                    if (!done_r) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dvd_raw_r;
                        dz_r        <= 1'b1;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dz_r;

endmodule : div_32bit_seq

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_div_32bit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_ZERO_EARLY_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    div_32bit_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: C-style truncating division, remainder follows dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        int     ia, ib;
        longint sa, sb, tq, tr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s) begin
            ia = a; ib = b;
            sa = ia; sb = ib;
            tq = sa / sb; tr = sa % sb;
            q = tq[31:0]; r = tr[31:0]; dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Issue one operation and check latency, busy, results and hold.
    // inj=1 pulses a competing 9/3 start at edge 5 after acceptance.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit inj);
        logic [31:0] eq, er;
        logic        edz;
        int          n;
        bit          seen, busy_ok;
        int          exp_lat;
        model(a, b, s, eq, er, edz);
        exp_lat = (b == 32'd0) ? DZ_LAT : 33;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (n < 100 && !seen) begin
            if (!busy) busy_ok = 1'b0;
            start = inj && (n == 4);
            if (start) begin
                dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, " latency"}, n, exp_lat);
        check_val({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        check_val({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_val({tag, " quotient"}, quotient, eq);
        check_val({tag, " remainder"}, remainder, er);
        check_val({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
        @(posedge clk); #1;
        check_val({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, " hold_q"}, quotient, eq);
        check_val({tag, " hold_r"}, remainder, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bit          extra_done;

        #12;
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done", {31'd0, done}, 32'd0);
        check_val("rst q", quotient, 32'd0);
        check_val("rst r", remainder, 32'd0);
        check_val("rst dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u100/7", 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("umax/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("u/0", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op("s/0", 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        run_op("ignore", 32'd1000, 32'd10, 1'b0, 1'b1);

        // Reset mid-RUN: everything clears at once and no done follows.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst busy", {31'd0, busy}, 32'd0);
        check_val("midrst done", {31'd0, done}, 32'd0);
        check_val("midrst q", quotient, 32'd0);
        check_val("midrst r", remainder, 32'd0);
        check_val("midrst dz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) extra_done = 1'b1;
        end
        check_val("midrst no_done", {31'd0, extra_done}, 32'd0);
        run_op("after_rst 9/3", 32'd9, 32'd3, 1'b0, 1'b0);

        // Randomized operations, biased toward interesting divisors.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(1, 0));
            case ($urandom_range(4, 0))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(15, 1));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
                3:       rb = $urandom >> $urandom_range(31, 0);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && i % 2 == 0) rb = 32'd3;
            run_op($sformatf("rnd%0d", i), ra, rb, rs, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_32bit_seq

// File: doc/div_32bit_seq.md
DIV_32BIT_SEQ -- requirements
Module: div_32bit_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand width; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 dividend  input  32  numerator; sampled with start.
REQ-008 divisor  input  32  denominator; sampled with start.
REQ-009 busy  output  1  high from the edge that accepts start until the edge that asserts done.
REQ-010 done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid while it is high.
REQ-011 quotient  output  32  result quotient.
REQ-012 remainder  output  32  result remainder; its sign SHALL follow the dividend in signed mode.
REQ-013 div_by_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-015 In IDLE with start=1, the edge SHALL latch both operands and their sign bits, and latch the absolute values (conditional invert plus increment when is_signed=1 and the MSB=1), clear the iteration counter, and go to RUN.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL negate the quotient if is_signed=1 and the operand signs differ.
REQ-018 FIX SHALL negate the remainder if is_signed=1 and the dividend is negative.
REQ-019 FIX SHALL register the outputs and go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE; start is not accepted in DONE.
REQ-021 Latency SHALL be 33 edges from the start-accepting edge to the edge that raises done.
REQ-022 start while busy=1 SHALL be ignored, with no effect on operands or results.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values after done until the next operation's FIX or the divide-by-zero completion edge.
REQ-024 Divisor = 0 SHALL produce quotient=0xFFFFFFFF, remainder=dividend and div_by_zero=1, in either mode.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient=0x80000000, remainder=0 and div_by_zero=0, with no trap.
REQ-026 The absolute value of 0x80000000 SHALL be treated as an unsigned 32-bit magnitude, with no overflow.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0, including mid-RUN; the aborted operation produces no done.
REQ-028 The first start after reset release SHALL behave as a fresh operation.

Configuration
REQ-029 The macro DIV_ZERO_EARLY_EN SHALL select the divide-by-zero path.
REQ-030 With DIV_ZERO_EARLY_EN defined, divisor=0 at start SHALL go directly to DONE, raising done on the next edge (latency 1) with the REQ-024 results.
REQ-031 Without DIV_ZERO_EARLY_EN, divisor=0 SHALL traverse RUN and FIX (latency 33), and FIX SHALL force the REQ-024 results.

Structure
REQ-032 Shared package div_pkg SHALL hold the state enum typedef, the WIDTH constant (32) and the counter width constant (6).
REQ-033 Sub-module cond_negate_32bit (in[31:0], neg, out[31:0]; out = (in XOR {32{neg}}) + neg) SHALL be instantiated for the operand absolute values and for the result fixup.

Verification
REQ-034 Unsigned 100 / 7 -> quotient=14, remainder=2, done exactly 33 edges after start, busy high throughout.
REQ-035 Signed -7 (0xFFFFFFF9) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0; unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-037 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1; latency 1 with DIV_ZERO_EARLY_EN, 33 without.
REQ-038 Start 1000 / 10, pulse start again at edge 5 with 9 / 3 -> second request ignored, result quotient=100, remainder=0.
REQ-039 Start 1000 / 10, drop rst_n at edge 10 -> busy=0 and outputs 0 immediately, no done pulse; a fresh start 9 / 3 -> quotient=3, remainder=0.
